// File: rtl/m_tlb_fa.sv
// Fully-associative TLB with ASID tags, 4 MiB superpages, sfence.vma-style selective flush,
// not-recently-used replacement and saturating hit/miss counters; lookups answer one cycle later.
module m_tlb_fa #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 22,
  parameter int ENTRIES = 8,
  parameter int ASID_W  = 9
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              w_lk_req,
  input  logic [VPN_W-1:0]  w_lk_vpn,
  input  logic [ASID_W-1:0] w_lk_asid,
  output logic              r_lk_valid,
  output logic              r_lk_hit,
  output logic [PPN_W-1:0]  r_lk_ppn,
  output logic [7:0]        r_lk_flags,
  input  logic              w_fill_we,
  input  logic [VPN_W-1:0]  w_fill_vpn,
  input  logic [ASID_W-1:0] w_fill_asid,
  input  logic [PPN_W-1:0]  w_fill_ppn,
  input  logic [7:0]        w_fill_flags,
  input  logic              w_fill_super,
  input  logic              w_flush,
  input  logic [1:0]        w_flush_mode,
  input  logic [VPN_W-1:0]  w_flush_vpn,
  input  logic [ASID_W-1:0] w_flush_asid,
  input  logic              w_cnt_clr,
  output logic [31:0]       r_hit_cnt,
  output logic [31:0]       r_miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [VPN_W-1:0]   r_vpn   [ENTRIES];
  logic [ASID_W-1:0]  r_asid  [ENTRIES];
  logic [PPN_W-1:0]   r_ppn   [ENTRIES];
  logic [7:0]         r_flags [ENTRIES];
  logic [ENTRIES-1:0] r_valid, r_ref, r_super;

  logic [ENTRIES-1:0] w_lk_match, w_fill_match, w_flush_clr;
  logic [ENTRIES-1:0] w_ref_hit, w_ref_post, w_valid_post, w_fill_oh;
  logic [ENTRIES-1:0] w_valid_nxt, w_ref_nxt;
  logic [PPN_W-1:0]   w_sel_ppn, w_lk_ppn;
  logic [7:0]         w_sel_flags;
  logic               w_sel_super, w_lk_hit, w_found;
  logic [IDX_W-1:0]   w_fill_idx;

  // Superpage tags keep the full VPN; only the level-1 bits take part in the compare.
  function automatic logic f_vpn_eq(input logic i_sup, input logic [VPN_W-1:0] i_tag,
                                    input logic [VPN_W-1:0] i_vpn);
    if (i_sup) return i_tag[VPN_W-1:10] == i_vpn[VPN_W-1:10];
    return i_tag == i_vpn;
  endfunction

  always_comb begin
    w_lk_match  = '0;
    w_flush_clr = '0;
    w_sel_ppn   = '0;
    w_sel_flags = '0;
    w_sel_super = 1'b0;
    for (int e = 0; e < ENTRIES; e++) begin
      w_lk_match[e] = r_valid[e] && (r_asid[e] == w_lk_asid || r_flags[e][5]) &&
                      f_vpn_eq(r_super[e], r_vpn[e], w_lk_vpn);
      if (w_lk_match[e]) begin
        w_sel_ppn   = w_sel_ppn | r_ppn[e];
        w_sel_flags = w_sel_flags | r_flags[e];
        w_sel_super = w_sel_super | r_super[e];
      end
      case (w_flush_mode)
        2'd0:    w_flush_clr[e] = 1'b1;
        2'd1:    w_flush_clr[e] = (r_asid[e] == w_flush_asid) && !r_flags[e][5];
        2'd2:    w_flush_clr[e] = f_vpn_eq(r_super[e], r_vpn[e], w_flush_vpn);
        default: w_flush_clr[e] = f_vpn_eq(r_super[e], r_vpn[e], w_flush_vpn) &&
                                  (r_asid[e] == w_flush_asid) && !r_flags[e][5];
      endcase
      w_flush_clr[e] = w_flush_clr[e] & w_flush;
    end
    w_lk_hit = |w_lk_match;
    w_lk_ppn = w_sel_super ? {w_sel_ppn[PPN_W-1:10], w_lk_vpn[9:0]} : w_sel_ppn;

    // NRU: once every valid entry is referenced, only the entry just hit keeps its ref bit.
    w_ref_hit = r_ref;
    if (w_lk_req && w_lk_hit) begin
      w_ref_hit = r_ref | w_lk_match;
      if ((r_valid & ~w_ref_hit) == '0) w_ref_hit = w_lk_match;
    end
    w_valid_post = r_valid & ~w_flush_clr;
    w_ref_post   = w_ref_hit & ~w_flush_clr;

    w_fill_match = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      w_fill_match[e] = w_valid_post[e] && (r_asid[e] == w_fill_asid || r_flags[e][5]) &&
                        f_vpn_eq(r_super[e], r_vpn[e], w_fill_vpn);
    end

    // Victim priority: existing match, lowest invalid, lowest unreferenced, entry 0.
    w_fill_idx = '0;
    w_found    = 1'b0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (w_fill_match[e]) begin
        w_fill_idx = IDX_W'(e);
        w_found    = 1'b1;
      end
    end
    if (!w_found) begin
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (!w_valid_post[e]) begin
          w_fill_idx = IDX_W'(e);
          w_found    = 1'b1;
        end
      end
    end
    if (!w_found) begin
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (!w_ref_post[e]) w_fill_idx = IDX_W'(e);
      end
    end

    w_fill_oh = '0;
    if (w_fill_we) w_fill_oh[w_fill_idx] = 1'b1;
    w_valid_nxt = w_valid_post | w_fill_oh;
    w_ref_nxt   = w_ref_post | w_fill_oh;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_valid    <= '0;
      r_ref      <= '0;
      r_lk_valid <= 1'b0;
      r_lk_hit   <= 1'b0;
      r_lk_ppn   <= '0;
      r_lk_flags <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lk_req) assert ($onehot0(w_lk_match));
      r_valid    <= w_valid_nxt;
      r_ref      <= w_ref_nxt;
      r_lk_valid <= w_lk_req;
      if (w_lk_req) begin
        r_lk_hit   <= w_lk_hit;
        r_lk_ppn   <= w_lk_ppn;
        r_lk_flags <= w_sel_flags;
      end
      // Counters update on the same edge that raises r_lk_valid; clear wins.
      if (w_cnt_clr) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else if (w_lk_req) begin
        if (w_lk_hit && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
        if (!w_lk_hit && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Entry payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_vpn[w_fill_idx]   <= w_fill_vpn;
      r_asid[w_fill_idx]  <= w_fill_asid;
      r_ppn[w_fill_idx]   <= w_fill_ppn;
      r_flags[w_fill_idx] <= w_fill_flags;
      r_super[w_fill_idx] <= w_fill_super;
    end
  end
endmodule

// File: tb/tb_m_tlb_fa.sv
// Bench for m_tlb_fa: directed scenarios plus random traffic, with a per-entry reference model
// and an expected-result queue drained by an independent monitor.
module tb_m_tlb_fa;
  localparam int N = 8;

  logic        CLK, RST_X;
  logic        w_lk_req;
  logic [19:0] w_lk_vpn;
  logic [8:0]  w_lk_asid;
  logic        r_lk_valid, r_lk_hit;
  logic [21:0] r_lk_ppn;
  logic [7:0]  r_lk_flags;
  logic        w_fill_we;
  logic [19:0] w_fill_vpn;
  logic [8:0]  w_fill_asid;
  logic [21:0] w_fill_ppn;
  logic [7:0]  w_fill_flags;
  logic        w_fill_super;
  logic        w_flush;
  logic [1:0]  w_flush_mode;
  logic [19:0] w_flush_vpn;
  logic [8:0]  w_flush_asid;
  logic        w_cnt_clr;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  m_tlb_fa #(.VPN_W(20), .PPN_W(22), .ENTRIES(N), .ASID_W(9)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_lk_req(w_lk_req), .w_lk_vpn(w_lk_vpn), .w_lk_asid(w_lk_asid),
    .r_lk_valid(r_lk_valid), .r_lk_hit(r_lk_hit), .r_lk_ppn(r_lk_ppn), .r_lk_flags(r_lk_flags),
    .w_fill_we(w_fill_we), .w_fill_vpn(w_fill_vpn), .w_fill_asid(w_fill_asid),
    .w_fill_ppn(w_fill_ppn), .w_fill_flags(w_fill_flags), .w_fill_super(w_fill_super),
    .w_flush(w_flush), .w_flush_mode(w_flush_mode), .w_flush_vpn(w_flush_vpn),
    .w_flush_asid(w_flush_asid), .w_cnt_clr(w_cnt_clr),
    .r_hit_cnt(r_hit_cnt), .r_miss_cnt(r_miss_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_mis = 0;

  // {hit, ppn, flags, hit_cnt, miss_cnt}
  logic [94:0] exp_q[$];

  // reference model: one record per TLB slot
  logic        m_valid [N];
  logic        m_ref   [N];
  logic        m_super [N];
  logic [19:0] m_vpn   [N];
  logic [8:0]  m_asid  [N];
  logic [21:0] m_ppn   [N];
  logic [7:0]  m_flags [N];
  logic [31:0] m_hc, m_mc;

  function automatic bit m_page_eq(int e, logic [19:0] vpn);
    if (m_super[e]) return m_vpn[e][19:10] == vpn[19:10];
    return m_vpn[e] == vpn;
  endfunction

  function automatic bit m_match(int e, logic [19:0] vpn, logic [8:0] asid);
    return m_valid[e] && (m_asid[e] == asid || m_flags[e][5]) && m_page_eq(e, vpn);
  endfunction

  task automatic m_reset();
    for (int e = 0; e < N; e++) begin
      m_valid[e] = 1'b0;
      m_ref[e]   = 1'b0;
      m_super[e] = 1'b0;
      m_vpn[e]   = '0;
      m_asid[e]  = '0;
      m_ppn[e]   = '0;
      m_flags[e] = '0;
    end
    m_hc = '0;
    m_mc = '0;
    exp_q.delete();
  endtask

  // Applies one clock's worth of stimulus to the model: lookup on old state, then flush, then fill.
  task automatic model_step();
    int          hi, t;
    bit          all_ref, clr;
    logic [21:0] ppn;
    logic [7:0]  flg;
    hi = -1;
    for (int e = N - 1; e >= 0; e--) if (m_match(e, w_lk_vpn, w_lk_asid)) hi = e;
    ppn = '0;
    flg = '0;
    if (w_lk_req) begin
      if (hi >= 0) begin
        ppn = m_super[hi] ? {m_ppn[hi][21:10], w_lk_vpn[9:0]} : m_ppn[hi];
        flg = m_flags[hi];
        m_ref[hi] = 1'b1;
        all_ref = 1'b1;
        for (int e = 0; e < N; e++) if (m_valid[e] && !m_ref[e]) all_ref = 1'b0;
        if (all_ref) for (int e = 0; e < N; e++) if (e != hi) m_ref[e] = 1'b0;
        if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
      end else if (m_mc != 32'hFFFF_FFFF) begin
        m_mc = m_mc + 1;
      end
    end
    if (w_cnt_clr) begin
      m_hc = '0;
      m_mc = '0;
    end
    if (w_lk_req) exp_q.push_back({(hi >= 0), ppn, flg, m_hc, m_mc});
    if (w_flush) begin
      for (int e = 0; e < N; e++) begin
        case (w_flush_mode)
          2'd0: clr = 1'b1;
          2'd1: clr = (m_asid[e] == w_flush_asid) && !m_flags[e][5];
          2'd2: clr = m_page_eq(e, w_flush_vpn);
          default: clr = m_page_eq(e, w_flush_vpn) && (m_asid[e] == w_flush_asid) && !m_flags[e][5];
        endcase
        if (clr) begin
          m_valid[e] = 1'b0;
          m_ref[e]   = 1'b0;
        end
      end
    end
    if (w_fill_we) begin
      t = -1;
      for (int e = N - 1; e >= 0; e--) if (m_match(e, w_fill_vpn, w_fill_asid)) t = e;
      if (t < 0) for (int e = N - 1; e >= 0; e--) if (!m_valid[e]) t = e;
      if (t < 0) for (int e = N - 1; e >= 0; e--) if (!m_ref[e]) t = e;
      if (t < 0) t = 0;
      m_valid[t] = 1'b1;
      m_ref[t]   = 1'b1;
      m_super[t] = w_fill_super;
      m_vpn[t]   = w_fill_vpn;
      m_asid[t]  = w_fill_asid;
      m_ppn[t]   = w_fill_ppn;
      m_flags[t] = w_fill_flags;
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    w_lk_req = 1'b0; w_fill_we = 1'b0; w_flush = 1'b0; w_cnt_clr = 1'b0;
  endtask

  task automatic apply();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic set_lookup(input logic [19:0] vpn, input logic [8:0] asid);
    w_lk_req = 1'b1; w_lk_vpn = vpn; w_lk_asid = asid;
  endtask

  task automatic set_fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                          input logic [7:0] flags, input logic sup);
    w_fill_we = 1'b1; w_fill_vpn = vpn; w_fill_asid = asid;
    w_fill_ppn = ppn; w_fill_flags = flags; w_fill_super = sup;
  endtask

  task automatic set_flush(input logic [1:0] mode, input logic [19:0] vpn, input logic [8:0] asid);
    w_flush = 1'b1; w_flush_mode = mode; w_flush_vpn = vpn; w_flush_asid = asid;
  endtask

  task automatic do_lookup(input logic [19:0] vpn, input logic [8:0] asid);
    set_lookup(vpn, asid); apply();
  endtask

  task automatic do_fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                         input logic [7:0] flags, input logic sup);
    set_fill(vpn, asid, ppn, flags, sup); apply();
  endtask

  task automatic do_flush(input logic [1:0] mode, input logic [19:0] vpn, input logic [8:0] asid);
    set_flush(mode, vpn, asid); apply();
  endtask

  task automatic check_direct(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Random page pools keep translations unique: 4K pages and superpages live in disjoint
  // regions, and the global bit is a fixed function of the page.
  task automatic pick_page(input bit allow_miss, output logic [19:0] vpn, output logic sup,
                           output logic g);
    int r;
    r = allow_miss ? $urandom_range(0, 9) : $urandom_range(0, 8);
    if (r <= 4) begin
      vpn = 20'h00400 + 20'($urandom_range(0, 15));
      sup = 1'b0;
      g   = vpn[3];
    end else if (r <= 8) begin
      vpn = {10'h200 + 10'($urandom_range(0, 3)), 10'($urandom)};
      sup = 1'b1;
      g   = vpn[10];
    end else begin
      vpn = {10'h3FF, 10'($urandom)};
      sup = 1'b0;
      g   = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [94:0] e;
    if (RST_X && r_lk_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL lk_unexpected: r_lk_valid=1 with no lookup outstanding");
      end else begin
        e = exp_q.pop_front();
        if ({r_lk_hit, r_lk_ppn, r_lk_flags, r_hit_cnt, r_miss_cnt} !== e) begin
          n_mis++;
          $display("FAIL lk_result: got hit=%0b ppn=%h flags=%h hc=%h mc=%h, want hit=%0b ppn=%h flags=%h hc=%h mc=%h",
                   r_lk_hit, r_lk_ppn, r_lk_flags, r_hit_cnt, r_miss_cnt,
                   e[94], e[93:72], e[71:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [19:0] vpn;
    logic        sup, g;
    logic [7:0]  flg;
    int          wait_cyc;
    RST_X = 1'b0;
    idle_inputs();
    w_lk_vpn = '0; w_lk_asid = '0; w_fill_vpn = '0; w_fill_asid = '0; w_fill_ppn = '0;
    w_fill_flags = '0; w_fill_super = 1'b0; w_flush_mode = '0; w_flush_vpn = '0; w_flush_asid = '0;
    m_reset();
    repeat (3) @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    check_direct("reset_lk_valid", 64'(r_lk_valid), 64'd0);
    check_direct("reset_counters", {r_hit_cnt, r_miss_cnt}, 64'd0);

    // empty TLB miss
    do_lookup(20'h12345, 9'd1);
    // basic fill / hit / ASID miss / overwrite
    do_fill(20'h12345, 9'd1, 22'h0ABCD, 8'hCF, 1'b0);
    do_lookup(20'h12345, 9'd1);
    do_lookup(20'h12345, 9'd2);
    do_fill(20'h12345, 9'd1, 22'h00001, 8'hCF, 1'b0);
    do_lookup(20'h12345, 9'd1);
    // global superpage
    do_fill(20'h80000, 9'd3, 22'h20000, 8'hEF, 1'b1);
    do_lookup(20'h803FF, 9'd7);
    do_flush(2'd1, 20'h0, 9'd3);
    do_lookup(20'h803FF, 9'd7);
    do_flush(2'd2, 20'h80155, 9'd0);
    do_lookup(20'h803FF, 9'd7);
    do_lookup(20'h12345, 9'd1);

    // NRU replacement with a repeatedly referenced entry 2
    do_flush(2'd0, 20'h0, 9'd0);
    for (int i = 0; i <= N; i++) begin
      do_fill(20'h10000 + 20'(i), 9'd1, 22'h100 + 22'(i), 8'h4F, 1'b0);
      if (i >= 2) do_lookup(20'h10002, 9'd1);
    end
    do_lookup(20'h10000, 9'd1);
    do_lookup(20'h10002, 9'd1);
    do_lookup(20'h10000 + 20'(N), 9'd1);

    // same-cycle ordering
    set_lookup(20'h22222, 9'd4); set_fill(20'h22222, 9'd4, 22'h3333, 8'h0F, 1'b0); apply();
    do_lookup(20'h22222, 9'd4);
    set_flush(2'd0, 20'h0, 9'd0); set_fill(20'h44444, 9'd4, 22'h5555, 8'h0F, 1'b0); apply();
    do_lookup(20'h22222, 9'd4);
    do_lookup(20'h10002, 9'd1);
    do_lookup(20'h44444, 9'd4);
    set_flush(2'd3, 20'h44444, 9'd4); set_lookup(20'h44444, 9'd4); apply();
    do_lookup(20'h44444, 9'd4);

    // hit counter saturation and clear priority
    do_fill(20'h55555, 9'd5, 22'h6666, 8'h0F, 1'b0);
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    m_hc = 32'hFFFF_FFFE;
    repeat (3) do_lookup(20'h55555, 9'd5);
    set_lookup(20'h55555, 9'd5); w_cnt_clr = 1'b1; apply();
    do_lookup(20'h55555, 9'd5);

    // random traffic
    do_flush(2'd0, 20'h0, 9'd0);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) < 6) begin
        pick_page(1'b1, vpn, sup, g);
        set_lookup(vpn, 9'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 9) < 3) begin
        pick_page(1'b0, vpn, sup, g);
        flg = 8'($urandom);
        flg[5] = g;
        set_fill(vpn, 9'($urandom_range(0, 3)), 22'($urandom), flg, sup);
      end
      if ($urandom_range(0, 19) == 0) begin
        pick_page(1'b1, vpn, sup, g);
        set_flush(2'($urandom_range(0, 3)), vpn, 9'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 49) == 0) w_cnt_clr = 1'b1;
      apply();
    end

    // reset in the middle of a lookup discards it
    @(negedge CLK);
    set_lookup(20'h00401, 9'd1);
    #2;
    RST_X = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_direct("rst_mid_lk_valid", 64'(r_lk_valid), 64'd0);
    check_direct("rst_mid_hit", 64'(r_lk_hit), 64'd0);
    check_direct("rst_mid_counters", {r_hit_cnt, r_miss_cnt}, 64'd0);
    idle_inputs();
    m_reset();
    RST_X = 1'b1;
    @(negedge CLK);
    do_lookup(20'h00401, 9'd1);
    do_lookup(20'h00402, 9'd2);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge CLK);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL lk_drain: %0d lookups never answered, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
